// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit segment scan controller:
// FSM state encoding and the dark-pin drive values.
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic [7:0] SEG_OFF = 8'h00;
    localparam logic [3:0] CS_OFF  = 4'hF;

endpackage

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit segment scanner with a double-buffered frame.
// The active buffer only changes at a frame boundary, so the display never tears.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       en,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [7:0] wr_data,
    input  logic       commit,
    output logic [7:0] seg,
    output logic [3:0] segcs,
    output logic       commit_pend,
    output logic       frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYC - 1);

    scan_state_t     r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_digit;
    logic [7:0]      r_seg;
    logic [3:0]      r_segcs;
    logic            r_frame_tick;
    logic            r_commit_pend;
    logic [3:0][7:0] r_shadow;
    logic [3:0][7:0] r_active;

    // Pins are computed from the current state, so they lag it by one cycle.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_digit      <= 2'd0;
            r_seg        <= SEG_OFF;
            r_segcs      <= CS_OFF;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            r_seg        <= SEG_OFF;
            r_segcs      <= CS_OFF;
            if (!en) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_digit <= 2'd0;
            end else begin
                if (r_state == ST_DRIVE) begin
                    r_segcs <= ~(4'b0001 << r_digit);
                    r_seg   <= r_active[r_digit];
                end
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_BLANK;
                        r_cnt   <= '0;
                        r_digit <= 2'd0;
                    end
                    ST_BLANK: begin
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= ST_DRIVE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (r_cnt == DRIVE_LAST) begin
                            r_state      <= ST_BLANK;
                            r_cnt        <= '0;
                            r_digit      <= r_digit + 2'd1;
                            r_frame_tick <= (r_digit == 2'd3);
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // A commit arriving on the tick cycle itself wins over the clear, so it lands next frame.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_shadow      <= '0;
            r_active      <= '0;
            r_commit_pend <= 1'b0;
        end else begin
            if (wr_en)
                r_shadow[wr_sel] <= wr_data;
            if (r_frame_tick && r_commit_pend) begin
                r_active      <= r_shadow;
                r_commit_pend <= 1'b0;
            end
            if (commit)
                r_commit_pend <= 1'b1;
        end
    end

    assign seg         = r_seg;
    assign segcs       = r_segcs;
    assign commit_pend = r_commit_pend;
    assign frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a phase-counting frame model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_seg_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * SD;

    logic       clk = 1'b0;
    logic       RSTn = 1'b0;
    logic       en = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_sel = 2'd0;
    logic [7:0] wr_data = 8'h00;
    logic       commit = 1'b0;
    logic [7:0] seg;
    logic [3:0] segcs;
    logic       commit_pend;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .RSTn(RSTn), .en(en), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .commit(commit), .seg(seg), .segcs(segcs),
        .commit_pend(commit_pend), .frame_tick(frame_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_phase counts cycles since the scanner left idle (-1 = idle).
    int              m_phase;
    logic [7:0]      m_seg;
    logic [3:0]      m_segcs;
    logic            m_tick;
    logic            m_pend;
    logic [3:0][7:0] m_shadow;
    logic [3:0][7:0] m_active;
    int              mpos;
    int              md;
    logic [3:0]      mcs;

    always @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            m_phase  <= -1;
            m_seg    <= 8'h00;
            m_segcs  <= 4'hF;
            m_tick   <= 1'b0;
            m_pend   <= 1'b0;
            m_shadow <= '0;
            m_active <= '0;
        end else begin
            if (en && m_phase >= 0) begin
                mpos = m_phase % FRAME;
                md   = mpos / SD;
                mcs  = 4'hF;
                mcs[md] = 1'b0;
                if (mpos % SD >= BC) begin
                    m_segcs <= mcs;
                    m_seg   <= m_active[md];
                end else begin
                    m_segcs <= 4'hF;
                    m_seg   <= 8'h00;
                end
                m_tick <= (mpos == FRAME - 1);
            end else begin
                m_segcs <= 4'hF;
                m_seg   <= 8'h00;
                m_tick  <= 1'b0;
            end
            if (m_tick && m_pend) begin
                m_active <= m_shadow;
                m_pend   <= 1'b0;
            end
            if (commit)
                m_pend <= 1'b1;
            if (wr_en)
                m_shadow[wr_sel] <= wr_data;
            m_phase <= en ? m_phase + 1 : -1;
        end
    end

    always @(negedge clk) begin
        chk("model_seg", seg, m_seg);
        chk("model_segcs", segcs, m_segcs);
        chk("model_tick", frame_tick, m_tick);
        chk("model_pend", commit_pend, m_pend);
        chk("cs_onehot", ($countones(~segcs) <= 1), 1);
    end

    task automatic negs(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 40);
        if (!frame_tick) chk("tick_timeout", 0, 1);
    endtask

    task automatic wr(input logic [1:0] s, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_sel = s; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_commit();
        @(posedge clk); #1;
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    initial begin
        // Reset state
        negs(3);
        chk("rst_seg", seg, 8'h00);
        chk("rst_segcs", segcs, 4'hF);
        chk("rst_pend", commit_pend, 0);
        chk("rst_tick", frame_tick, 0);
        @(posedge clk); #1;
        RSTn = 1'b1;

        // Load a frame and commit it; check one full slot sequence
        en = 1'b1;
        wr(2'd0, 8'h3F); wr(2'd1, 8'h06); wr(2'd2, 8'h5B); wr(2'd3, 8'h4F);
        pulse_commit();
        @(negedge clk);
        chk("pend_rise", commit_pend, 1);
        wait_tick();
        chk("pend_at_tick", commit_pend, 1);
        negs(1); chk("k1_pend", commit_pend, 0); chk("k1_cs", segcs, 4'hF);
        negs(1); chk("k2_cs", segcs, 4'hF);
        negs(1); chk("k3_cs", segcs, 4'hE); chk("k3_seg", seg, 8'h3F);
        negs(5); chk("k8_cs", segcs, 4'hE);
        negs(1); chk("k9_cs", segcs, 4'hF);
        negs(2); chk("k11_cs", segcs, 4'hD); chk("k11_seg", seg, 8'h06);
        negs(8); chk("k19_cs", segcs, 4'hB); chk("k19_seg", seg, 8'h5B);
        negs(8); chk("k27_cs", segcs, 4'h7); chk("k27_seg", seg, 8'h4F);
        negs(5); chk("period32", frame_tick, 1);

        // Commit on the tick cycle is deferred one frame
        wr(2'd0, 8'h77);
        wait_tick();
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
        @(negedge clk); chk("late_pend", commit_pend, 1);
        negs(2); chk("late_old_seg", seg, 8'h3F);
        wait_tick();
        negs(3); chk("late_new_seg", seg, 8'h77); chk("late_pend_clr", commit_pend, 0);

        // Write on the tick cycle: copy takes the pre-write shadow
        wr(2'd2, 8'h66);
        pulse_commit();
        wait_tick();
        wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'hFF;
        @(posedge clk); #1;
        wr_en = 1'b0;
        @(negedge clk);
        negs(18); chk("wt_d2_old", seg, 8'h66); chk("wt_d2_cs", segcs, 4'hB);
        wait_tick();
        negs(19); chk("wt_d2_hold", seg, 8'h66);
        pulse_commit();
        wait_tick();
        negs(19); chk("wt_d2_new", seg, 8'hFF);

        // Drop enable during digit-1 drive, then re-enable
        wait_tick();
        negs(12); chk("drop_cs_before", segcs, 4'hD);
        en = 1'b0;
        negs(1); chk("drop_seg", seg, 8'h00); chk("drop_cs", segcs, 4'hF);
        negs(40);
        en = 1'b1;
        negs(3); chk("re_blank", segcs, 4'hF);
        negs(1); chk("re_cs", segcs, 4'hE); chk("re_seg", seg, 8'h77);

        // Async reset mid-drive: pins dark before any clock edge
        #2 RSTn = 1'b0;
        #1;
        chk("arst_seg", seg, 8'h00);
        chk("arst_cs", segcs, 4'hF);
        chk("arst_pend", commit_pend, 0);
        @(posedge clk); #1;
        RSTn = 1'b1;
        wait_tick();
        negs(3); chk("post_rst_cs", segcs, 4'hE); chk("post_rst_d0", seg, 8'h00);
        negs(16); chk("post_rst_d2", seg, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
